// File: rtl/key_queue.sv
// Keycode conditioner: glitch filter, arrow-press FIFO, frame-synchronous output register.
// Optional KEY_QUEUE_HOLD_EN: an empty FIFO re-presents a still-held arrow each frame.
module key_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic [7:0]                     keycode_in,
  input  logic                           frame_in,
  output logic [7:0]                     key_out,
  output logic                           key_valid,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
  output logic                           overflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [7:0]    r_raw;
  logic [7:0]    r_last_acc;
  logic [SW-1:0] r_stab;
  logic [1:0]    r_sync;
  logic          r_sync_d;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_is_arrow;
  logic w_accept;
  logic w_push;
  logic w_push_ok;
  logic w_pop;
  logic w_frame_pulse;
  logic w_full;
`ifdef KEY_QUEUE_HOLD_EN
  logic w_last_arrow;
  assign w_last_arrow = (r_last_acc >= 8'h4F) && (r_last_acc <= 8'h52);
`endif

  always_comb begin
    w_is_arrow    = (r_raw >= 8'h4F) && (r_raw <= 8'h52);
    w_accept      = (r_stab == STAB_MAX) && (r_raw != r_last_acc);
    w_push        = w_accept && w_is_arrow;
    w_frame_pulse = r_sync[1] && !r_sync_d;
    w_pop         = w_frame_pulse && (r_count != '0);
    w_full        = (r_count == COUNT_FULL);
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    w_push_ok     = w_push && (!w_full || w_pop);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_raw      <= 8'h00;
      r_last_acc <= 8'h00;
      r_stab     <= '0;
      r_sync     <= 2'b00;
      r_sync_d   <= 1'b0;
    end else begin
      r_raw    <= keycode_in;
      r_sync   <= {r_sync[0], frame_in};
      r_sync_d <= r_sync[1];
      if (keycode_in != r_raw) begin
        r_stab <= '0;
      end else if (r_stab != STAB_MAX) begin
        r_stab <= r_stab + 1'b1;
      end
      if (w_accept) begin
        r_last_acc <= r_raw;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge Clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_raw;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      overflow  <= 1'b0;
      key_out   <= 8'h00;
      key_valid <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_push && !w_push_ok) begin
        overflow <= 1'b1;
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
      if (w_frame_pulse) begin
        if (w_pop) begin
          key_out   <= r_mem[r_rd_ptr];
          key_valid <= 1'b1;
          r_rd_ptr  <= r_rd_ptr + 1'b1;
        end else begin
`ifdef KEY_QUEUE_HOLD_EN
          key_out <= w_last_arrow ? r_last_acc : 8'h00;
`else
          key_out <= 8'h00;
`endif
          key_valid <= 1'b0;
        end
      end
    end
  end

  assign fifo_count = r_count;

endmodule

// File: tb/tb_key_queue.sv
// Scoreboard bench for key_queue: queue-based reference model, frame-triggered output monitor.
module tb_key_queue;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned STABLE = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       frame = 1'b0;
  logic [7:0] key_out;
  logic       key_valid;
  logic [2:0] fifo_count;
  logic       overflow;

  key_queue #(.DEPTH(DEPTH), .STABLE_CYCLES(STABLE)) dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .keycode_in(keycode),
    .frame_in  (frame),
    .key_out   (key_out),
    .key_valid (key_valid),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] k;
    logic       v;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_prev;
  logic [7:0] mq[$];
  logic [7:0] m_last;
  logic       m_ovf;
  logic [7:0] m_cur;
  int         m_len;
  bit         acc_pend;
  logic [7:0] acc_code;
  int         frm_cnt;
  bit         m_prev_frame;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  function automatic bit is_arrow(input logic [7:0] c);
    return (c >= 8'h4F) && (c <= 8'h52);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, check occupancy just after.
  task automatic tick(input logic [7:0] code, input logic frm);
    bit   acc_now;
    bit   frm_now;
    exp_t e;
    @(negedge clk);
    keycode = code;
    frame   = frm;
    @(posedge clk);
    acc_now  = acc_pend;
    acc_pend = 0;
    frm_now  = (frm_cnt == 1);
    if (frm_cnt > 0) frm_cnt--;
    if (frm_now) begin
      e.k = 8'h00;
      e.v = 1'b0;
      if (mq.size() > 0) begin
        e.k = mq.pop_front();
        e.v = 1'b1;
      end
`ifdef KEY_QUEUE_HOLD_EN
      else if (is_arrow(m_last)) e.k = m_last;
`endif
      exp_q.push_back(e);
    end
    if (acc_now && acc_code != m_last) begin
      if (is_arrow(acc_code)) begin
        if (mq.size() < DEPTH) mq.push_back(acc_code);
        else m_ovf = 1'b1;
      end
      m_last = acc_code;
    end
    if (code == m_cur) m_len++;
    else begin
      m_cur = code;
      m_len = 1;
    end
    if (m_len == STABLE) begin
      acc_pend = 1;
      acc_code = code;
    end
    if (frm && !m_prev_frame) frm_cnt = 2;
    m_prev_frame = frm;
    #1;
    chk("fifo_count", int'(fifo_count), mq.size());
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic hold(input logic [7:0] code, input int n);
    repeat (n) tick(code, 1'b0);
  endtask

  task automatic do_frame(input logic [7:0] code);
    tick(code, 1'b1);
    tick(code, 1'b1);
    repeat (4) tick(code, 1'b0);
  endtask

  task automatic do_reset();
    repeat (6) tick(keycode, 1'b0);
    @(negedge clk);
    keycode = 8'h00;
    frame   = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_key_out", int'(key_out), 0);
    chk("rst_key_valid", int'(key_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    mq.delete();
    m_last       = 8'h00;
    m_ovf        = 1'b0;
    m_cur        = 8'h00;
    m_len        = 1;
    acc_pend     = 0;
    frm_cnt      = 0;
    m_prev_frame = 0;
    mon_prev.k   = 8'h00;
    mon_prev.v   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: output must hold for two edges after a frame rise, then match the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge frame);
      repeat (2) @(posedge clk);
      #2;
      chk("key_out_early", int'(key_out), int'(mon_prev.k));
      chk("key_valid_early", int'(key_valid), int'(mon_prev.v));
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_output: got %0h/%0b expected none queued", key_out, key_valid);
      end else begin
        e = exp_q.pop_front();
        chk("key_out", int'(key_out), int'(e.k));
        chk("key_valid", int'(key_valid), int'(e.v));
        mon_prev = e;
      end
    end
  end

  initial begin
    logic [7:0] burst[5];
    logic [7:0] code;
    int         r;
    int         n;
    burst[0] = 8'h4F;
    burst[1] = 8'h50;
    burst[2] = 8'h51;
    burst[3] = 8'h52;
    burst[4] = 8'h4F;

    do_reset();
    repeat (3) do_frame(8'h00);

    hold(8'h52, 10);
    hold(8'h00, 30);

    hold(8'h50, 40);
    hold(8'h00, 20);
    do_frame(8'h00);
    do_frame(8'h00);

    foreach (burst[i]) begin
      hold(burst[i], 20);
      hold(8'h00, 20);
    end
    repeat (5) do_frame(8'h00);

    // Push commit and frame pulse land on the same edge with the FIFO empty.
    hold(8'h00, 20);
    for (int i = 1; i <= 30; i++) tick(8'h51, (i == 15 || i == 16));
    hold(8'h00, 20);
    do_frame(8'h00);

    hold(8'h51, 20);
    repeat (4) do_frame(8'h51);
    hold(8'h00, 20);
    do_frame(8'h00);

    hold(8'h4F, 20);
    hold(8'h00, 20);
    hold(8'h50, 20);
    do_reset();
    hold(8'h00, 5);

    for (int s = 0; s < 80; s++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) code = 8'h4F + 8'(r);
      else if (r <= 6) code = 8'h00;
      else if (r == 7) code = 8'h04;
      else code = 8'($urandom);
      n = $urandom_range(1, 30);
      repeat (n) begin
        cyc++;
        tick(code, (cyc % 20) < 3);
      end
    end
    hold(8'h00, 30);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
